pipe_hazard_ctrl: RTL

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Central stall / flush / redirect controller for a five-stage in-order
// pipeline (IF, ID, EX, MEM, WB) with a multi-cycle mul/div unit in EX.
//
// Priority of hazard sources, highest first:
//   memory wait > mul/div wait > control redirect > load-use
//
// Ports
//   clk, rst_n        : rising-edge clock, asynchronous active-low reset
//   id_rs1_idx/rs2_idx: source register indices of the ID instruction
//   id_use_rs1/rs2    : ID instruction actually reads rs1 / rs2
//   ex_rd_idx         : destination index of the EX instruction
//   ex_is_load        : EX instruction is a load with write-back
//   ex_redirect       : jal/jalr/taken branch resolved in EX
//   ex_redirect_pc    : redirect target
//   ex_md_start       : first EX cycle of a multi-cycle mul/div op
//   md_done           : mul/div result valid this cycle
//   mem_req/mem_ready : MEM-stage data access request / completion
//   if_hold, id_hold  : PC and IF/ID registers keep their value
//   ex_stall_n        : ID/EX stall_n (low loads a bubble into EX)
//   ex_flush          : ID/EX flush
//   id_flush          : zeroes the IF/ID register
//   ex_hold, mem_hold : EX/MEM and MEM/WB registers keep their value
//   wb_bubble         : MEM/WB loads a bubble
//   pc_redirect(_tgt) : PC load request and target
//   stall_cnt         : saturating count of cycles with if_hold high
// ----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [4:0]      id_rs1_idx,
    input  logic [4:0]      id_rs2_idx,
    input  logic            id_use_rs1,
    input  logic            id_use_rs2,
    input  logic [4:0]      ex_rd_idx,
    input  logic            ex_is_load,
    input  logic            ex_redirect,
    input  logic [XLEN-1:0] ex_redirect_pc,
    input  logic            ex_md_start,
    input  logic            md_done,
    input  logic            mem_req,
    input  logic            mem_ready,
    output logic            if_hold,
    output logic            id_hold,
    output logic            ex_stall_n,
    output logic            ex_flush,
    output logic            id_flush,
    output logic            ex_hold,
    output logic            mem_hold,
    output logic            wb_bubble,
    output logic            pc_redirect,
    output logic [XLEN-1:0] pc_redirect_tgt,
    output logic [15:0]     stall_cnt
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        MDWAIT  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            md_busy;       // a mul/div op is outstanding (survives MEMWAIT)
    logic            md_busy_nxt;
    logic            redir_pend;
    logic [XLEN-1:0] redir_pend_tgt;

    logic            mem_stall;
    logic            md_wait;
    logic            md_stall;
    logic            any_stall;
    logic            redirect_now;
    logic            rs1_hit;
    logic            rs2_hit;
    logic            load_use;

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
    assign mem_stall = mem_req && !mem_ready;

    // An MD op is waited on in MDWAIT, or in MEMWAIT when one was already
    // outstanding. The md_done cycle releases; a start in the same cycle
    // is a fresh op and keeps the hold.
    assign md_wait  = (state == MDWAIT) || ((state == MEMWAIT) && md_busy);
    assign md_stall = ex_md_start || (md_wait && !md_done);

    assign any_stall = mem_stall || md_stall;

    // A pending redirect takes precedence over a fresh one so the deferred
    // target is issued exactly once.
    assign redirect_now = !any_stall && (redir_pend || ex_redirect);

    assign rs1_hit  = id_use_rs1 && (id_rs1_idx == ex_rd_idx);
    assign rs2_hit  = id_use_rs2 && (id_rs2_idx == ex_rd_idx);
    assign load_use = !any_stall && !redirect_now && ex_is_load &&
                      (ex_rd_idx != 5'd0) && (rs1_hit || rs2_hit);

    assign md_busy_nxt = ex_md_start || (md_busy && !md_done);

    always_comb begin
        state_nxt = RUN;
        if (mem_stall)
            state_nxt = MEMWAIT;
        else if (md_busy_nxt)
            state_nxt = MDWAIT;
    end

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------
    // NOTE: every output gets a default before the priority chain so no
    // path leaves a signal unassigned, which would infer a latch.
    always_comb begin
        if_hold         = 1'b0;
        id_hold         = 1'b0;
        ex_stall_n      = 1'b1;
        ex_flush        = 1'b0;
        id_flush        = 1'b0;
        ex_hold         = 1'b0;
        mem_hold        = 1'b0;
        wb_bubble       = 1'b0;
        pc_redirect     = 1'b0;
        pc_redirect_tgt = '0;

        if (mem_stall) begin
            if_hold   = 1'b1;
            id_hold   = 1'b1;
            ex_hold   = 1'b1;
            mem_hold  = 1'b1;
            wb_bubble = 1'b1;
        end else if (md_stall) begin
            // MEM/WB keeps flowing; EX/MEM is held on the MD op.
            if_hold = 1'b1;
            id_hold = 1'b1;
            ex_hold = 1'b1;
        end else if (redirect_now) begin
            pc_redirect     = 1'b1;
            pc_redirect_tgt = redir_pend ? redir_pend_tgt : ex_redirect_pc;
            id_flush        = 1'b1;
            ex_flush        = 1'b1;
        end else if (load_use) begin
            if_hold    = 1'b1;
            id_hold    = 1'b1;
            ex_stall_n = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // State, pending redirect and stall counter
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments and resets
    // asynchronously, so a reset mid-wait abandons it without a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= RUN;
            md_busy        <= 1'b0;
            redir_pend     <= 1'b0;
            redir_pend_tgt <= '0;
            stall_cnt      <= '0;
        end else begin
            state   <= state_nxt;
            md_busy <= md_busy_nxt;

            // Capture the first redirect seen while EX is held; later
            // assertions by the same held instruction are ignored.
            if (any_stall && ex_redirect && !redir_pend) begin
                redir_pend     <= 1'b1;
                redir_pend_tgt <= ex_redirect_pc;
            end else if (redirect_now && redir_pend) begin
                redir_pend     <= 1'b0;
                redir_pend_tgt <= '0;
            end

            if (if_hold && (stall_cnt != 16'hFFFF))
                stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule
